// File: rtl/pulse_separator.sv
// Turns a level-high request into one-cycle output pulses separated by at least one low cycle.
// Requests that arrive faster than they can be emitted are held in a saturating pending counter.
module pulse_separator #(
   parameter int PULSE_COUNTER_WIDTH = 4
) (
   input  logic clock,
   input  logic resetn,
   input  logic pulse_in,
   output logic pulse_out,
   output logic busy
);

   localparam int W = PULSE_COUNTER_WIDTH;
   localparam logic [W-1:0] MAX        = '1;
   localparam logic [W-1:0] BUSY_LEVEL = MAX - 1'b1;

   logic [W-1:0] count;

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] c, input logic inc);
      return (inc && (c != MAX)) ? c + 1'b1 : c;
   endfunction

   // While a pulse is on the output, a new request can only be banked; otherwise an
   // idle request bypasses the counter and is emitted directly.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pulse_out <= 1'b0;
         count     <= '0;
      end else if (pulse_out) begin
         pulse_out <= 1'b0;
         count     <= sat_inc(count, pulse_in);
      end else if ((count != '0) || pulse_in) begin
         pulse_out <= 1'b1;
         if (!pulse_in) begin
            count <= count - 1'b1;
         end
      end
   end

   // Raised one step early so the request sampled on the rising edge still fits.
   assign busy = (count >= BUSY_LEVEL);

endmodule

// File: tb/tb_pulse_separator.sv
// Directed bench for pulse_separator (W=6): stimulus queues the expected cycle of every
// output pulse, and a negedge monitor pops and compares each pulse as it appears.
module tb_pulse_separator;

   localparam int W = 6;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   logic pulse_in = 1'b0;
   logic pulse_out;
   logic busy;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   int pulses = 0;
   int q[$];
   logic prev = 1'b0;

   pulse_separator #(.PULSE_COUNTER_WIDTH(W)) dut (
      .clock(clock),
      .resetn(resetn),
      .pulse_in(pulse_in),
      .pulse_out(pulse_out),
      .busy(busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Pulses for a request run starting after edge s: one at s+1, then every second cycle.
   task automatic push_train(input int s, input int n);
      for (int k = 0; k < n; k++) q.push_back(s + 1 + 2 * k);
   endtask

   task automatic drain(input string nm, input int budget);
      int w;
      w = 0;
      while (q.size() != 0 && w < budget) begin
         @(posedge clock);
         w++;
      end
      chk({nm, "_drained"}, q.size(), 0);
      repeat (4) @(posedge clock);
      #1;
      chk({nm, "_out_low"}, int'(pulse_out), 0);
      chk({nm, "_busy_low"}, int'(busy), 0);
   endtask

   // Monitor: every output pulse must match the next queued cycle and never follow a high cycle.
   always @(negedge clock) begin
      if (!resetn) begin
         prev = 1'b0;
      end else begin
         if (pulse_out === 1'b1) begin
            pulses++;
            chk("back_to_back", int'(prev), 0);
            if (q.size() == 0) chk("unexpected_pulse", cyc, -1);
            else chk("pulse_cycle", cyc, q.pop_front());
         end
         prev = pulse_out;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int n;
      int p0;

      repeat (3) @(posedge clock);
      #1;
      chk("rst_pulse_out", int'(pulse_out), 0);
      chk("rst_busy", int'(busy), 0);
      resetn = 1'b1;

      // single-cycle request
      @(posedge clock); #1;
      s = cyc;
      push_train(s, 1);
      pulse_in = 1'b1;
      @(posedge clock); #1;
      pulse_in = 1'b0;
      drain("single", 20);

      // four-cycle level
      @(posedge clock); #1;
      s = cyc;
      push_train(s, 4);
      pulse_in = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      pulse_in = 1'b0;
      drain("level4", 30);

      // alternating 1,0 four times
      @(posedge clock); #1;
      s = cyc;
      push_train(s, 4);
      for (int i = 0; i < 4; i++) begin
         pulse_in = 1'b1;
         @(posedge clock); #1;
         pulse_in = 1'b0;
         @(posedge clock); #1;
      end
      drain("alt4", 30);

      // hold until busy, then drop
      @(posedge clock); #1;
      s = cyc;
      push_train(s, 124);
      p0 = pulses;
      pulse_in = 1'b1;
      n = 0;
      while (!busy && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      pulse_in = 1'b0;
      chk("busy_rise_cycle", n, 124);
      chk("pulses_at_busy", pulses - p0, 62);
      drain("until_busy", 400);
      chk("until_busy_total", pulses - p0, 124);

      // hold 300 cycles ignoring busy: counter saturates at 63
      @(posedge clock); #1;
      s = cyc;
      push_train(s, 213);
      p0 = pulses;
      pulse_in = 1'b1;
      repeat (300) @(posedge clock);
      #1;
      chk("busy_saturated", int'(busy), 1);
      chk("pulses_during_hold", pulses - p0, 150);
      pulse_in = 1'b0;
      p0 = pulses;
      drain("saturate", 400);
      chk("drain_after_drop", pulses - p0, 63);

      // reset in the middle of a busy train while pulse_out is high
      @(posedge clock); #1;
      s = cyc;
      push_train(s, 64);
      pulse_in = 1'b1;
      repeat (129) @(posedge clock);
      #1;
      chk("pre_rst_pulse_high", int'(pulse_out), 1);
      chk("pre_rst_busy_high", int'(busy), 1);
      resetn = 1'b0;
      pulse_in = 1'b0;
      #1;
      chk("mid_rst_pulse_out", int'(pulse_out), 0);
      chk("mid_rst_busy", int'(busy), 0);
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;
      p0 = pulses;
      repeat (150) @(posedge clock);
      #1;
      chk("post_rst_no_pulses", pulses - p0, 0);
      chk("post_rst_queue", q.size(), 0);
      chk("post_rst_busy", int'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
